// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// 1-bit full-adder cell driven LSB-first by serial_adder_ctrl.
module fulladderfour (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: WIDTH-cycle LSB-first add through one full-adder cell.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_co;

    fulladderfour u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_co)
    );

    assign sum_out = result;
    assign cout    = carry;

    // NOTE: in_ready/out_valid/busy are updated alongside the state so they stay
    // pure flops with no combinational path from in_valid or out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            result    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= a_in;
                        b_sr     <= b_in;
                        carry    <= cin_in;
                        cnt      <= '0;
                        result   <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    result <= {fa_sum, result[WIDTH-1:1]};
                    carry  <= fa_co;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        // carry still holds the carry into the MSB on this edge
                        ovf       <= carry ^ fa_co;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
